out_reg_display: RTL and testbench

- Output stage downstream of the CPU output register; consumes its 16-bit value and displays it on the board's four user LEDs one nibble at a time.
- Sweeps nibbles MS-first, with a dwell timer per nibble and a blank gap between sweeps.
- Tri-colour LED 0 (PWM-dimmed) shows which nibble is on screen; tri-colour LED 1 shows value-valid / error status.
- Captures a new value whenever the output register is written, so the display tracks the latest result.

---
 rtl/out_reg_display.sv | 125 ++++++++++++
 tb/tb_out_reg_display.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/out_reg_display.sv
// Sweeps a captured output-register value across the user LEDs MS nibble first, with tri-colour status LEDs.
// Shows the new MS nibble 1 cycle after load; no backpressure (load is always accepted, last load wins).
module out_reg_display #(
  parameter int DATA_WIDTH   = 16,
  parameter int DWELL_CYCLES = 50000000,
  parameter int GAP_CYCLES   = 25000000,
  parameter int PWM_WIDTH    = 8,
  parameter int BRIGHTNESS   = 32,
  localparam int NUM_NIB     = DATA_WIDTH / 4,
  localparam int NIB_W       = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  err,
  output logic [3:0]            led,
  output logic [NIB_W-1:0]      nib_idx,
  output logic [1:0]            rled,
  output logic [1:0]            gled,
  output logic [1:0]            bled
);

  // One counter serves both the dwell and the gap phases, so size it for the longer one.
  localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [NIB_W-1:0]     NIB_LAST   = NIB_W'(NUM_NIB - 1);
  localparam logic [PWM_WIDTH-1:0] BRIGHT     = PWM_WIDTH'(BRIGHTNESS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   held_q, held_nxt;
  logic                    valid_q, valid_nxt;
  logic [CNT_W-1:0]        cnt_q, cnt_nxt;
  logic [NIB_W-1:0]        nib_nxt;
  logic [PWM_WIDTH-1:0]    pwm_cnt;
  logic                    pwm_on;
  logic [1:0]              col_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      held_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      nib_idx <= '0;
      pwm_cnt <= '0;
    end else begin
      state   <= state_nxt;
      held_q  <= held_nxt;
      valid_q <= valid_nxt;
      cnt_q   <= cnt_nxt;
      nib_idx <= nib_nxt;
      pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    held_nxt  = held_q;
    valid_nxt = valid_q;
    cnt_nxt   = cnt_q;
    nib_nxt   = nib_idx;
    case (state)
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_nxt = '0;
          if (nib_idx == NIB_LAST) state_nxt = GAP;
          else                     nib_nxt   = nib_idx + NIB_W'(1);
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_nxt   = '0;
          nib_nxt   = '0;
          state_nxt = SHOW;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    // A fresh capture overrides any terminal-count transition in the same cycle.
    if (load) begin
      held_nxt  = load_data;
      valid_nxt = 1'b1;
      state_nxt = SHOW;
      nib_nxt   = '0;
      cnt_nxt   = '0;
    end
  end

  assign pwm_on  = (pwm_cnt < BRIGHT);
  assign col_sel = 2'(nib_idx);

  always_comb begin
    led  = 4'd0;
    rled = 2'b00;
    gled = 2'b00;
    bled = 2'b00;
    if (state == SHOW) begin
      for (int i = 0; i < NUM_NIB; i++) begin
        if (nib_idx == NIB_W'(i)) led = held_q[DATA_WIDTH-1-4*i -: 4];
      end
      if (pwm_on) begin
        rled[0] = (col_sel == 2'd0) || (col_sel == 2'd3);
        gled[0] = (col_sel == 2'd1) || (col_sel == 2'd3);
        bled[0] = (col_sel == 2'd2) || (col_sel == 2'd3);
      end
    end
    rled[1] = err & pwm_on;
    gled[1] = valid_q & ~err & pwm_on;
  end

endmodule

// File: tb/tb_out_reg_display.sv
// Randomised and directed bench for out_reg_display against a sweep-time reference model.
module tb_out_reg_display;

  localparam int DW     = 16;
  localparam int NN     = DW / 4;
  localparam int DWELL  = 4;
  localparam int GAPC   = 2;
  localparam int PWMW   = 3;
  localparam int BRT    = 2;
  localparam int PERIOD = NN * DWELL + GAPC;
  localparam int PWMMOD = 1 << PWMW;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [DW-1:0] load_data;
  logic          err;
  logic [3:0]    led, led_d;
  logic [1:0]    nib_idx, nib_idx_d;
  logic [1:0]    rled, gled, bled, rled_d, gled_d, bled_d;

  int checks = 0;
  int errors = 0;

  // Reference model state: sweep position t within one period.
  int          m_t;
  int          m_pwm;
  logic        m_valid;
  logic [DW-1:0] m_held;

  always #5 clk = ~clk;

  out_reg_display #(
    .DATA_WIDTH(DW), .DWELL_CYCLES(DWELL), .GAP_CYCLES(GAPC),
    .PWM_WIDTH(PWMW), .BRIGHTNESS(BRT)
  ) u_dut (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data), .err(err),
    .led(led), .nib_idx(nib_idx), .rled(rled), .gled(gled), .bled(bled)
  );

  out_reg_display #(
    .DATA_WIDTH(DW), .DWELL_CYCLES(DWELL), .GAP_CYCLES(GAPC),
    .PWM_WIDTH(PWMW), .BRIGHTNESS(0)
  ) u_dim (
    .clk(clk), .reset(reset), .load(load), .load_data(load_data), .err(err),
    .led(led_d), .nib_idx(nib_idx_d), .rled(rled_d), .gled(gled_d), .bled(bled_d)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_held  = '0;
      m_valid = 1'b0;
      m_t     = 0;
      m_pwm   = 0;
    end else begin
      m_pwm = (m_pwm + 1) % PWMMOD;
      if (load) begin
        m_held  = load_data;
        m_valid = 1'b1;
        m_t     = 0;
      end else if (m_valid) begin
        m_t = (m_t + 1) % PERIOD;
      end
    end
  endtask

  task automatic check_outputs();
    logic       on;
    int         idx, c;
    logic [3:0] e_led;
    logic       r0, g0, b0;
    on    = (m_pwm < BRT);
    e_led = 4'd0;
    idx   = 0;
    r0 = 1'b0; g0 = 1'b0; b0 = 1'b0;
    if (m_valid && m_t < NN * DWELL) begin
      idx   = m_t / DWELL;
      e_led = 4'((m_held >> (4 * (NN - 1 - idx))) & 16'hF);
      c     = idx % 4;
      r0    = on && (c == 0 || c == 3);
      g0    = on && (c == 1 || c == 3);
      b0    = on && (c == 2 || c == 3);
    end else if (m_valid) begin
      idx = NN - 1;
    end
    chk("led", 32'(led), 32'(e_led));
    chk("nib_idx", 32'(nib_idx), 32'(idx));
    chk("rled", 32'(rled), 32'({err & on, r0}));
    chk("gled", 32'(gled), 32'({m_valid & ~err & on, g0}));
    chk("bled", 32'(bled), 32'({1'b0, b0}));
    chk("dim_colour", 32'({rled_d, gled_d, bled_d}), 32'd0);
    chk("dim_led", 32'(led_d), 32'(e_led));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_load(input logic [DW-1:0] d);
    load      = 1'b1;
    load_data = d;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_data = '0; err = 1'b0;
    m_t = 0; m_pwm = 0; m_valid = 1'b0; m_held = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();

    do_load(16'hA5C3);
    repeat (2 * PERIOD + 2) tick();

    // Reload mid-sweep on the second cycle of nibble 2.
    do_load(16'h1234);
    repeat (2 * DWELL + 1) tick();
    do_load(16'hFEDC);
    chk("reload_led", 32'(led), 32'h0000000F);
    chk("reload_idx", 32'(nib_idx), 32'd0);
    repeat (DWELL + 2) tick();

    // Load coincident with the dwell terminal count of the last nibble.
    do_load(16'h9876);
    repeat (NN * DWELL - 1) tick();
    do_load(16'h4321);
    chk("term_led", 32'(led), 32'h00000004);
    repeat (PERIOD) tick();

    err = 1'b1;
    repeat (12) tick();
    err = 1'b0;
    repeat (12) tick();

    // Reset together with load mid-SHOW: reset wins.
    do_load(16'hABCD);
    repeat (5) tick();
    reset = 1'b1; load = 1'b1; load_data = 16'h0F0F;
    tick();
    reset = 1'b0; load = 1'b0;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_gled1", 32'(gled[1]), 32'd0);
    repeat (3) tick();
    do_load(16'h0F0F);
    repeat (PERIOD) tick();

    for (int i = 0; i < 3000; i++) begin
      load      = ($urandom_range(0, 39) == 0);
      load_data = DW'($urandom);
      if ($urandom_range(0, 49) == 0) err = ~err;
      reset     = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
